// File: rtl/io_tx_fifo.sv
// Byte FIFO between the CPU-side I/O bus and the UART output stage.
// Bytes are drained one at a time using the output stage's trigger/ready handshake.
`timescale 1ns/1ps

module io_tx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               wr_value,
  input  logic                     wr_trigger,
  input  logic                     overflow_clear,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [7:0]               io_output_value,
  output logic                     io_output_trigger,
  input  logic                     io_output_ready_trigger
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // state      | meaning
  // IDLE       | waiting for data and an idle output stage
  // SEND       | trigger pulse is on the wire for this cycle
  // WAIT_ACK   | waiting for the output stage to drop ready (byte accepted)
  // WAIT_READY | waiting for ready to return (frame finished)
  typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK, WAIT_READY} state_t;

  state_t          state_q, state_d;
  logic [7:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            full_q, full_d;
  logic            empty_q, empty_d;
  logic            overflow_q, overflow_d;
  logic [7:0]      value_q, value_d;
  logic            trig_q, trig_d;
  logic            wr_en;
  logic            issue;

  always_comb begin
    // full is the registered flag, so a write in a pop cycle while full is still dropped
    wr_en = wr_trigger && !full_q;
    issue = (state_q == IDLE) && !empty_q && io_output_ready_trigger;

    wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = issue ? rd_ptr_q + AW'(1) : rd_ptr_q;

    count_d = count_q;
    if (wr_en && !issue) begin
      count_d = count_q + CW'(1);
    end else if (!wr_en && issue) begin
      count_d = count_q - CW'(1);
    end
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);

    overflow_d = overflow_q;
    if (wr_trigger && full_q) begin
      overflow_d = 1'b1;
    end else if (overflow_clear) begin
      overflow_d = 1'b0;
    end

    value_d = issue ? mem_q[rd_ptr_q] : value_q;
    trig_d  = issue;

    state_d = state_q;
    case (state_q)
      IDLE:       if (issue) state_d = SEND;
      SEND:       state_d = WAIT_ACK;
      WAIT_ACK:   if (!io_output_ready_trigger) state_d = WAIT_READY;
      WAIT_READY: if (io_output_ready_trigger) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      value_q    <= 8'h00;
      trig_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
      value_q    <= value_d;
      trig_q     <= trig_d;
    end
  end

  // Storage needs no reset: entries are only read once the count says they are valid
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= wr_value;
    end
  end

  assign full              = full_q;
  assign empty             = empty_q;
  assign count             = count_q;
  assign overflow          = overflow_q;
  assign io_output_value   = value_q;
  assign io_output_trigger = trig_q;

endmodule

// File: tb/tb_io_tx_fifo.sv
// Directed bench for io_tx_fifo with a simple UART output-stage model
// (drops ready one cycle after a trigger, raises it again 10 cycles later).
`timescale 1ns/1ps

module tb_io_tx_fifo;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] wr_value = 8'h00;
  logic       wr_trigger = 1'b0;
  logic       overflow_clear = 1'b0;
  logic       full, empty, overflow;
  logic [4:0] count;
  logic [7:0] io_output_value;
  logic       io_output_trigger;
  logic       io_output_ready_trigger = 1'b1;

  int n_asserts = 0;
  int n_fail = 0;
  int trig_count = 0;
  int tick = 0;
  int tc;
  logic ds_en = 1'b0;
  logic prev_trig = 1'b0;
  logic rdy_at_edge = 1'b0;
  logic [7:0] rx [$];

  io_tx_fifo #(.DEPTH(16)) dut (
    .clk(clk),
    .reset(reset),
    .wr_value(wr_value),
    .wr_trigger(wr_trigger),
    .overflow_clear(overflow_clear),
    .full(full),
    .empty(empty),
    .count(count),
    .overflow(overflow),
    .io_output_value(io_output_value),
    .io_output_trigger(io_output_trigger),
    .io_output_ready_trigger(io_output_ready_trigger)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) rdy_at_edge <= io_output_ready_trigger;

  // Trigger monitor: capture bytes, check pulse width and ready qualification
  always @(negedge clk) begin
    if (io_output_trigger) begin
      trig_count++;
      rx.push_back(io_output_value);
      check("trig_width", {31'd0, prev_trig}, 32'd0);
      check("trig_ready", {31'd0, rdy_at_edge}, 32'd1);
    end
    prev_trig = io_output_trigger;
  end

  // Output-stage model
  always @(negedge clk) begin
    if (ds_en) begin
      if (io_output_trigger) begin
        io_output_ready_trigger = 1'b0;
        tick = 10;
      end else if (tick > 0) begin
        tick--;
        if (tick == 0) io_output_ready_trigger = 1'b1;
      end
    end
  end

  task automatic push(input logic [7:0] b);
    int g = 0;
    while (full && g < 100) begin
      @(negedge clk);
      g++;
    end
    wr_value = b;
    wr_trigger = 1'b1;
    @(negedge clk);
    wr_trigger = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int budget);
    int g = 0;
    while (rx.size() < n && g < budget) begin
      @(negedge clk);
      g++;
    end
    check("rx_count", rx.size(), n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset and idle
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_count", count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_value", io_output_value, 8'h00);
    check("rst_trigger", io_output_trigger, 0);
    repeat (20) @(negedge clk);
    check("idle_trig_count", trig_count, 0);
    check("idle_empty", empty, 1);
    check("idle_count", count, 0);

    // Single byte
    ds_en = 1'b1;
    wr_value = 8'hA5;
    wr_trigger = 1'b1;
    @(negedge clk);
    wr_trigger = 1'b0;
    check("single_count_1", count, 1);
    check("single_trig_lo", io_output_trigger, 0);
    @(negedge clk);
    check("single_trig_hi", io_output_trigger, 1);
    check("single_value", io_output_value, 8'hA5);
    check("single_count_0", count, 0);
    repeat (20) @(negedge clk);
    check("single_rx_n", rx.size(), 1);
    check("single_rx_0", rx[0], 8'hA5);
    check("single_trig_n", trig_count, 1);
    check("single_value_hold", io_output_value, 8'hA5);

    // Burst fill to full, then drain in order
    ds_en = 1'b0;
    io_output_ready_trigger = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      wr_value = 8'(i);
      wr_trigger = 1'b1;
      @(negedge clk);
    end
    wr_trigger = 1'b0;
    check("burst_full", full, 1);
    check("burst_count", count, 16);
    check("burst_no_trig", trig_count, 1);
    io_output_ready_trigger = 1'b1;
    ds_en = 1'b1;
    wait_rx(17, 600);
    for (int i = 0; i < 16; i++) check("burst_order", rx[1 + i], 32'(i + 1));
    repeat (15) @(negedge clk);
    check("burst_empty", empty, 1);

    // Overflow handling
    ds_en = 1'b0;
    io_output_ready_trigger = 1'b0;
    for (int i = 0; i < 16; i++) begin
      wr_value = 8'h20 + 8'(i);
      wr_trigger = 1'b1;
      @(negedge clk);
    end
    wr_value = 8'hFF;
    @(negedge clk);
    wr_trigger = 1'b0;
    check("ovf_set", overflow, 1);
    check("ovf_count", count, 16);
    check("ovf_full", full, 1);
    overflow_clear = 1'b1;
    @(negedge clk);
    check("ovf_clear", overflow, 0);
    wr_trigger = 1'b1;
    @(negedge clk);
    wr_trigger = 1'b0;
    check("ovf_set_wins", overflow, 1);
    check("ovf_count2", count, 16);
    @(negedge clk);
    overflow_clear = 1'b0;
    check("ovf_clear2", overflow, 0);
    io_output_ready_trigger = 1'b1;
    ds_en = 1'b1;
    wait_rx(33, 600);
    for (int i = 0; i < 16; i++) check("ovf_order", rx[17 + i], 32'h20 + 32'(i));
    repeat (15) @(negedge clk);
    check("ovf_no_ff", rx.size(), 33);

    // Simultaneous push/pop at count 3, then 40 bytes across the wrap
    ds_en = 1'b0;
    io_output_ready_trigger = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_value = 8'h40 + 8'(i);
      wr_trigger = 1'b1;
      @(negedge clk);
    end
    wr_trigger = 1'b0;
    check("pp_count_pre", count, 3);
    wr_value = 8'h43;
    wr_trigger = 1'b1;
    io_output_ready_trigger = 1'b1;
    ds_en = 1'b1;
    @(negedge clk);
    wr_trigger = 1'b0;
    check("pp_count_same", count, 3);
    check("pp_trig", io_output_trigger, 1);
    for (int i = 4; i < 40; i++) push(8'h40 + 8'(i));
    wait_rx(73, 1200);
    for (int i = 0; i < 40; i++) check("pp_order", rx[33 + i], 32'h40 + 32'(i));
    repeat (15) @(negedge clk);

    // Async reset while in WAIT_READY with 5 bytes queued
    ds_en = 1'b0;
    io_output_ready_trigger = 1'b0;
    for (int i = 0; i < 6; i++) begin
      wr_value = 8'h60 + 8'(i);
      wr_trigger = 1'b1;
      @(negedge clk);
    end
    wr_trigger = 1'b0;
    check("rst_mid_count6", count, 6);
    io_output_ready_trigger = 1'b1;
    ds_en = 1'b1;
    @(negedge clk);
    repeat (4) @(negedge clk);
    check("rst_mid_count5", count, 5);
    check("rst_mid_value", io_output_value, 8'h60);
    check("rst_mid_ready", io_output_ready_trigger, 0);
    #2;
    reset = 1'b1;
    #1;
    check("arst_count", count, 0);
    check("arst_empty", empty, 1);
    check("arst_full", full, 0);
    check("arst_value", io_output_value, 8'h00);
    check("arst_trigger", io_output_trigger, 0);
    check("arst_overflow", overflow, 0);
    @(negedge clk);
    reset = 1'b0;
    tc = trig_count;
    repeat (30) @(negedge clk);
    check("post_rst_no_trig", trig_count, tc);
    check("post_rst_empty", empty, 1);
    push(8'h77);
    wait_rx(75, 50);
    check("post_rst_byte", rx[74], 8'h77);
    check("post_rst_trig_n", trig_count, tc + 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
